// File: rtl/dct_quant.sv
// Per-position quantize/dequantize stage between dct and idct (3-stage pipeline).
// Optional DCT_QUANT_ROUND_EN: round half away from zero on magnitude; otherwise truncate.
module dct_quant #(
  parameter int unsigned BitWidth = 31,
  parameter int unsigned QSCALE   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [BitWidth:0] din,
  output logic              done,
  output logic [BitWidth:0] dout,
  output logic              busy
);

  localparam int unsigned CW = 14;
  localparam int unsigned IW = 6;
  localparam int unsigned QW = 8;
  localparam int unsigned RW = 17;
  localparam int unsigned DW = 22;

`ifdef DCT_QUANT_ROUND_EN
  localparam logic [31:0] RND = 32'd32768;
`else
  localparam logic [31:0] RND = 32'd0;
`endif

  // JPEG luminance table, row-major, index 0 first
  localparam logic [0:63][7:0] LUMA = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  function automatic logic [0:63][QW-1:0] build_q();
    logic [0:63][QW-1:0] t;
    int unsigned v;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      v = (32'(LUMA[i]) * 32'(QSCALE) + 32'd4) >> 3;
      if (v < 32'd1) v = 32'd1;
      else if (v > 32'd255) v = 32'd255;
      t[i] = QW'(v);
    end
    return t;
  endfunction

  function automatic logic [0:63][RW-1:0] build_r(input logic [0:63][QW-1:0] q);
    logic [0:63][RW-1:0] t;
    t = '0;
    for (int i = 0; i < 64; i++)
      t[i] = RW'((32'd65536 + 32'(q[i] >> 1)) / 32'(q[i]));
    return t;
  endfunction

  localparam logic [0:63][QW-1:0] Q_TAB = build_q();
  localparam logic [0:63][RW-1:0] R_TAB = build_r(Q_TAB);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic          accept;
  logic          valid_prev;

  logic          s1_v, s1_sign;
  logic [CW-1:0] s1_mag;
  logic [QW-1:0] s1_q;
  logic [RW-1:0] s1_r;
  logic          s2_v, s2_sign;
  logic [CW-1:0] s2_qm;
  logic [QW-1:0] s2_q;

  logic [CW-1:0] coef_c, mag_c, qm_c, deq_c;
  logic [DW-1:0] dm_c;
  logic          unused_lsbs;

  assign coef_c      = din[BitWidth -: CW];
  assign unused_lsbs = ^din[BitWidth-CW:0];
  assign mag_c       = coef_c[CW-1] ? CW'(~coef_c + 14'd1) : coef_c;
  assign qm_c        = CW'((32'(s1_mag) * 32'(s1_r) + RND) >> 16);
  assign dm_c        = DW'(s2_qm) * DW'(s2_q);

  // Sign reapplied after saturating to the 14-bit signed range
  always_comb begin
    deq_c = '0;
    if (!s2_sign)
      deq_c = (dm_c > 22'd8191) ? 14'h1fff : dm_c[CW-1:0];
    else
      deq_c = (dm_c > 22'd8192) ? 14'h2000 : CW'(~dm_c + 22'd1);
  end

  // A block only starts on a fresh din_valid rise, so a level held across reset is ignored
  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid && !valid_prev) begin
          accept     = 1'b1;
          idx_next   = idx + 6'd1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (din_valid) begin
          accept   = 1'b1;
          idx_next = idx + 6'd1;
          if (idx == 6'd63) state_next = DRAIN;
        end else begin
          idx_next   = '0;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (!din_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      valid_prev <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      valid_prev <= din_valid;
      busy       <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_q    <= '0;
      s1_r    <= '0;
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_qm   <= '0;
      s2_q    <= '0;
      done    <= 1'b0;
      dout    <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_sign <= coef_c[CW-1];
        s1_mag  <= mag_c;
        s1_q    <= Q_TAB[idx];
        s1_r    <= R_TAB[idx];
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sign <= s1_sign;
        s2_qm   <= qm_c;
        s2_q    <= s1_q;
      end
      done <= s2_v;
      if (s2_v) dout <= {{(BitWidth + 1 - CW){deq_c[CW-1]}}, deq_c};
    end
  end

endmodule
